multicycle_ctrl: RTL

- Multicycle successor to the single-cycle control decoder.
- FSM sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables per state.
- Waits on memory ready handshakes, traps illegal encodings and counts retired instructions.
- Sits between the IR/ALU-flag datapath and the register file, PC, ALU and unified memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 102 ++++++++++
 rtl/multicycle_ctrl_if.sv | 47 ++++
 rtl/multicycle_ctrl_decode.sv | 57 +++++
 rtl/multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - FSM state encoding (also exported on the debug state port)
//   - instruction classes produced by the decoder
//   - ALUOp_* operation codes and EXT_* immediate-extension codes
//   - datapath mux select codes (pc_src, reg_dst, wb_sel, alu_src_b)
//   - opcode / funct constants for the supported instruction subset
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   // FSM states; the numeric values are visible on the debug port
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   // Instruction classes: enough to steer the FSM and the registered fields
   typedef enum logic [3:0] {
      C_RTYPE   = 4'd0,
      C_SHIFT   = 4'd1,
      C_ITYPE   = 4'd2,
      C_LUI     = 4'd3,
      C_LOAD    = 4'd4,
      C_STORE   = 4'd5,
      C_BRANCH  = 4'd6,
      C_JUMP    = 4'd7,
      C_JAL     = 4'd8,
      C_JR      = 4'd9,
      C_ILLEGAL = 4'd10
   } iclass_t;

   // ALU operation codes
   localparam logic [4:0] ALUOp_AND  = 5'd0;
   localparam logic [4:0] ALUOp_OR   = 5'd1;
   localparam logic [4:0] ALUOp_ADD  = 5'd2;
   localparam logic [4:0] ALUOp_ADDU = 5'd3;
   localparam logic [4:0] ALUOp_SUB  = 5'd6;
   localparam logic [4:0] ALUOp_SUBU = 5'd7;
   localparam logic [4:0] ALUOp_SLT  = 5'd8;
   localparam logic [4:0] ALUOp_SLL  = 5'd9;
   localparam logic [4:0] ALUOp_SRL  = 5'd10;
   localparam logic [4:0] ALUOp_SRA  = 5'd11;
   localparam logic [4:0] ALUOp_LUI  = 5'd12;

   // Immediate extension modes
   localparam logic [1:0] EXT_ZERO    = 2'd0;
   localparam logic [1:0] EXT_SIGNED  = 2'd1;
   localparam logic [1:0] EXT_HIGHPOS = 2'd2;

   // PC source select
   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   // Register file destination select
   localparam logic [1:0] REG_DST_RT  = 2'b00;
   localparam logic [1:0] REG_DST_RD  = 2'b01;
   localparam logic [1:0] REG_DST_R31 = 2'b10;

   // Write-back source select
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC  = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUB_RT   = 2'b00;
   localparam logic [1:0] ALUB_IMM  = 2'b01;
   localparam logic [1:0] ALUB_FOUR = 2'b10;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle controller and its datapath / memory port.
//   master : the controller (consumes IR fields, ALU flag, mem_ready;
//            drives all enables, mux selects, status and debug state)
//   slave  : the datapath / memory side (the mirror image)
// Parameters: ALUCTRL_W (alu_ctrl width), CNT_W (instr_count width).
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int unsigned ALUCTRL_W = 5,
   parameter int unsigned CNT_W     = 32
);
   logic [5:0]           opcode;
   logic [5:0]           funct;
   logic                 alu_zero;
   logic                 mem_ready;
   logic                 mem_re;
   logic                 mem_we;
   logic                 ir_we;
   logic                 pc_we;
   logic [1:0]           pc_src;
   logic                 reg_we;
   logic [1:0]           reg_dst;
   logic [1:0]           wb_sel;
   logic                 alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           ext_op;
   logic [ALUCTRL_W-1:0] alu_ctrl;
   logic                 illegal;
   logic                 retire;
   logic [CNT_W-1:0]     instr_count;
   logic [2:0]           state;

   modport master (
      input  opcode, funct, alu_zero, mem_ready,
      output mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel,
             alu_src_a, alu_src_b, ext_op, alu_ctrl, illegal, retire,
             instr_count, state
   );

   modport slave (
      output opcode, funct, alu_zero, mem_ready,
      input  mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel,
             alu_src_a, alu_src_b, ext_op, alu_ctrl, illegal, retire,
             instr_count, state
   );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_decode
// Purely combinational instruction decoder.
//   opcode, funct : IR[31:26], IR[5:0]
//   iclass        : instruction class steering the FSM
//   alu_op        : ALUOp_* code for the EXEC cycle
//   ext_op        : EXT_* immediate extension for the EXEC cycle
// Any opcode or R-type funct outside the supported set maps to C_ILLEGAL.
// ---------------------------------------------------------------------------
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic [4:0] alu_op,
   output logic [1:0] ext_op
);

   // Opcode/funct to class, ALU operation and extension mode
   always_comb begin
      iclass = C_ILLEGAL;
      alu_op = ALUOp_ADD;
      ext_op = EXT_SIGNED;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_SLL:   begin iclass = C_SHIFT; alu_op = ALUOp_SLL;  end
               F_SRL:   begin iclass = C_SHIFT; alu_op = ALUOp_SRL;  end
               F_SRA:   begin iclass = C_SHIFT; alu_op = ALUOp_SRA;  end
               F_JR:    begin iclass = C_JR;    alu_op = ALUOp_ADD;  end
               F_ADD:   begin iclass = C_RTYPE; alu_op = ALUOp_ADD;  end
               F_ADDU:  begin iclass = C_RTYPE; alu_op = ALUOp_ADDU; end
               F_SUB:   begin iclass = C_RTYPE; alu_op = ALUOp_SUB;  end
               F_SUBU:  begin iclass = C_RTYPE; alu_op = ALUOp_SUBU; end
               F_AND:   begin iclass = C_RTYPE; alu_op = ALUOp_AND;  end
               F_OR:    begin iclass = C_RTYPE; alu_op = ALUOp_OR;   end
               F_SLT:   begin iclass = C_RTYPE; alu_op = ALUOp_SLT;  end
               default: begin iclass = C_ILLEGAL; end
            endcase
         end
         OP_J:    begin iclass = C_JUMP; end
         OP_JAL:  begin iclass = C_JAL;  end
         // Branches compare by subtraction and look at the zero flag
         OP_BEQ,
         OP_BNE:  begin iclass = C_BRANCH; alu_op = ALUOp_SUBU; end
         OP_ADDI: begin iclass = C_ITYPE;  alu_op = ALUOp_ADD; end
         OP_SLTI: begin iclass = C_ITYPE;  alu_op = ALUOp_SLT; end
         OP_ORI:  begin iclass = C_ITYPE;  alu_op = ALUOp_OR;  ext_op = EXT_ZERO; end
         OP_LUI:  begin iclass = C_LUI;    alu_op = ALUOp_LUI; ext_op = EXT_HIGHPOS; end
         OP_LW:   begin iclass = C_LOAD;   alu_op = ALUOp_ADD; end
         OP_SW:   begin iclass = C_STORE;  alu_op = ALUOp_ADD; end
         default: begin iclass = C_ILLEGAL; end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle MIPS control unit. Sequences each instruction through
// FETCH / DECODE / EXEC / MEM / WB, waits on mem_ready where configured,
// traps illegal encodings and counts retired instructions.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; aborts any instruction at once
//   bus  : multicycle_ctrl_if.master - IR fields, ALU zero flag and
//          mem_ready in; memory requests, datapath enables, mux selects,
//          illegal, retire, instr_count and debug state out
// Parameters:
//   ALUCTRL_W     : alu_ctrl width
//   MEM_HANDSHAKE : 1 = memory states wait for mem_ready, 0 = single cycle
//   CNT_W         : instr_count width
//   TRAP_HALT     : 1 = illegal opcode parks in TRAP, 0 = skip and refetch
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W     = 5,
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter int unsigned CNT_W         = 32,
   parameter bit          TRAP_HALT     = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   state_t               state_r;
   state_t               next_state_s;

   iclass_t              dec_class_s;
   logic [4:0]           dec_alu_op_s;
   logic [1:0]           dec_ext_op_s;

   // Fields captured on the DECODE->EXEC edge
   iclass_t              class_r;
   logic                 bne_r;
   logic [ALUCTRL_W-1:0] alu_ctrl_r;
   logic [1:0]           ext_op_r;
   logic                 alu_src_a_r;
   logic [1:0]           alu_src_b_r;
   logic [1:0]           reg_dst_r;
   logic [1:0]           wb_sel_r;

   logic                 illegal_r;
   logic [CNT_W-1:0]     count_r;

   logic                 ready_s;
   logic                 latch_fields_s;
   logic                 illegal_set_s;
   logic                 mem_re_s;
   logic                 mem_we_s;
   logic                 ir_we_s;
   logic                 pc_we_s;
   logic [1:0]           pc_src_s;
   logic                 reg_we_s;
   logic [1:0]           reg_dst_s;
   logic [1:0]           wb_sel_s;
   logic                 alu_src_a_s;
   logic [1:0]           alu_src_b_s;
   logic [1:0]           ext_op_s;
   logic [ALUCTRL_W-1:0] alu_ctrl_s;
   logic                 retire_s;

   multicycle_ctrl_decode u_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .iclass (dec_class_s),
      .alu_op (dec_alu_op_s),
      .ext_op (dec_ext_op_s)
   );

   // Without the handshake every memory access completes in its first cycle
   assign ready_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      next_state_s   = state_r;
      latch_fields_s = 1'b0;
      illegal_set_s  = 1'b0;
      mem_re_s       = 1'b0;
      mem_we_s       = 1'b0;
      ir_we_s        = 1'b0;
      pc_we_s        = 1'b0;
      pc_src_s       = PC_SRC_PC4;
      reg_we_s       = 1'b0;
      retire_s       = 1'b0;
      // Outside DECODE the ALU/mux fields show the registered decode
      reg_dst_s      = reg_dst_r;
      wb_sel_s       = wb_sel_r;
      alu_src_a_s    = alu_src_a_r;
      alu_src_b_s    = alu_src_b_r;
      ext_op_s       = ext_op_r;
      alu_ctrl_s     = alu_ctrl_r;
      // While reset is held every request and enable stays low
      if (rst) begin
         next_state_s = S_FETCH;
      end else begin
         case (state_r)
            S_FETCH: begin
               mem_re_s = 1'b1;
               if (ready_s) begin
                  ir_we_s      = 1'b1;
                  pc_we_s      = 1'b1;
                  next_state_s = S_DECODE;
               end else begin
                  next_state_s = S_FETCH;
               end
            end
            S_DECODE: begin
               // ALU speculatively forms the branch target pc+4 + (imm<<2)
               alu_src_a_s = 1'b0;
               alu_src_b_s = ALUB_IMM;
               ext_op_s    = EXT_SIGNED;
               alu_ctrl_s  = ALUCTRL_W'(ALUOp_ADD);
               case (dec_class_s)
                  C_JUMP: begin
                     pc_we_s      = 1'b1;
                     pc_src_s     = PC_SRC_JUMP;
                     retire_s     = 1'b1;
                     next_state_s = S_FETCH;
                  end
                  C_JAL: begin
                     // Link register takes the already-incremented PC
                     pc_we_s      = 1'b1;
                     pc_src_s     = PC_SRC_JUMP;
                     reg_we_s     = 1'b1;
                     reg_dst_s    = REG_DST_R31;
                     wb_sel_s     = WB_SEL_PC;
                     retire_s     = 1'b1;
                     next_state_s = S_FETCH;
                  end
                  C_JR: begin
                     pc_we_s      = 1'b1;
                     pc_src_s     = PC_SRC_RS;
                     retire_s     = 1'b1;
                     next_state_s = S_FETCH;
                  end
                  C_ILLEGAL: begin
                     illegal_set_s = 1'b1;
                     next_state_s  = TRAP_HALT ? S_TRAP : S_FETCH;
                  end
                  default: begin
                     latch_fields_s = 1'b1;
                     next_state_s   = S_EXEC;
                  end
               endcase
            end
            S_EXEC: begin
               case (class_r)
                  C_BRANCH: begin
                     // beq takes on zero, bne on non-zero
                     pc_we_s      = bus.alu_zero ^ bne_r;
                     pc_src_s     = PC_SRC_BRANCH;
                     retire_s     = 1'b1;
                     next_state_s = S_FETCH;
                  end
                  C_LOAD,
                  C_STORE: begin
                     next_state_s = S_MEM;
                  end
                  default: begin
                     next_state_s = S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (class_r == C_STORE) begin
                  mem_we_s = 1'b1;
                  if (ready_s) begin
                     retire_s     = 1'b1;
                     next_state_s = S_FETCH;
                  end else begin
                     next_state_s = S_MEM;
                  end
               end else begin
                  mem_re_s = 1'b1;
                  if (ready_s) begin
                     next_state_s = S_WB;
                  end else begin
                     next_state_s = S_MEM;
                  end
               end
            end
            S_WB: begin
               reg_we_s     = 1'b1;
               retire_s     = 1'b1;
               next_state_s = S_FETCH;
            end
            S_TRAP: begin
               next_state_s = S_TRAP;
            end
            default: begin
               next_state_s = S_FETCH;
            end
         endcase
      end
   end

   // Decoded fields, captured once per instruction on DECODE->EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         class_r     <= C_RTYPE;
         bne_r       <= 1'b0;
         alu_ctrl_r  <= '0;
         ext_op_r    <= EXT_ZERO;
         alu_src_a_r <= 1'b0;
         alu_src_b_r <= ALUB_RT;
         reg_dst_r   <= REG_DST_RT;
         wb_sel_r    <= WB_SEL_ALU;
      end else if (latch_fields_s) begin
         class_r     <= dec_class_s;
         bne_r       <= (bus.opcode == OP_BNE);
         alu_ctrl_r  <= ALUCTRL_W'(dec_alu_op_s);
         ext_op_r    <= dec_ext_op_s;
         alu_src_a_r <= (dec_class_s == C_SHIFT);
         alu_src_b_r <= (dec_class_s inside {C_RTYPE, C_SHIFT, C_BRANCH}) ? ALUB_RT : ALUB_IMM;
         reg_dst_r   <= (dec_class_s inside {C_RTYPE, C_SHIFT}) ? REG_DST_RD : REG_DST_RT;
         wb_sel_r    <= (dec_class_s == C_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
      end
   end

   // Sticky illegal-instruction flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_r <= 1'b0;
      end else if (illegal_set_s) begin
         illegal_r <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (retire_s) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign bus.mem_re      = mem_re_s;
   assign bus.mem_we      = mem_we_s;
   assign bus.ir_we       = ir_we_s;
   assign bus.pc_we       = pc_we_s;
   assign bus.pc_src      = pc_src_s;
   assign bus.reg_we      = reg_we_s;
   assign bus.reg_dst     = reg_dst_s;
   assign bus.wb_sel      = wb_sel_s;
   assign bus.alu_src_a   = alu_src_a_s;
   assign bus.alu_src_b   = alu_src_b_s;
   assign bus.ext_op      = ext_op_s;
   assign bus.alu_ctrl    = alu_ctrl_s;
   assign bus.illegal     = illegal_r;
   assign bus.retire      = retire_s;
   assign bus.instr_count = count_r;
   assign bus.state       = state_r;

endmodule
